// File: rtl/dnn_train_monitor.sv
// Per-case scoring of DNN a_out against y_out, with saturating totals and a sliding-window correct count.
// Optional SCORE_ACC_EN adds act_in and a per-case sum of |actL - y| (case_abs_err).
module dnn_train_monitor #(
  parameter int cpc    = 18,
  parameter int OUT_W  = 1,
  parameter int WINDOW = 100,
  parameter int CNT_W  = 32,
  parameter int ACT_W  = 32,
  parameter int FRAC   = 21
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [$clog2(cpc)-1:0]         cycle_index,
  input  logic [OUT_W-1:0]               a_out,
  input  logic [OUT_W-1:0]               y_out,
`ifdef SCORE_ACC_EN
  input  logic [ACT_W-1:0]               act_in,
  output logic [ACT_W+$clog2(cpc)-1:0]   case_abs_err,
`endif
  output logic                           case_done,
  output logic                           case_correct,
  output logic [CNT_W-1:0]               num_cases,
  output logic [CNT_W-1:0]               total_errors,
  output logic [$clog2(WINDOW+1)-1:0]    recent_correct,
  output logic                           window_full
);

  localparam int IDX_W = $clog2(cpc);
  localparam int RC_W  = $clog2(WINDOW+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(cpc - 1);
  localparam logic [RC_W-1:0]  WIN_MAX  = RC_W'(WINDOW);

  logic              mismatch;
  logic              scoring;
  logic              commit;
  logic              verdict;
  logic              oldest;
  logic              err_acc;
  logic [WINDOW-1:0] win_sr;
  logic [RC_W-1:0]   fill;
  logic [RC_W-1:0]   fill_next;
  logic [RC_W-1:0]   rc_next;

  always_comb begin
    mismatch  = |(a_out ^ y_out);
    scoring   = en && (cycle_index >= IDX_W'(2)) && (cycle_index <= LAST_IDX);
    commit    = scoring && (cycle_index == LAST_IDX);
    verdict   = ~(err_acc | mismatch);
    // The verdict leaving the window only counts once the window has filled.
    oldest    = (fill == WIN_MAX) ? win_sr[WINDOW-1] : 1'b0;
    rc_next   = recent_correct + RC_W'(verdict) - RC_W'(oldest);
    fill_next = (fill == WIN_MAX) ? fill : fill + RC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_acc <= 1'b0;
    end else if (commit || cycle_index == '0) begin
      err_acc <= 1'b0;
    end else if (scoring) begin
      err_acc <= err_acc | mismatch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      case_done      <= 1'b0;
      case_correct   <= 1'b0;
      num_cases      <= '0;
      total_errors   <= '0;
      recent_correct <= '0;
      window_full    <= 1'b0;
      win_sr         <= '0;
      fill           <= '0;
    end else begin
      case_done <= commit;
      if (commit) begin
        case_correct <= verdict;
        // total_errors never exceeds num_cases, so gating on num_cases saturates both.
        if (num_cases != '1) begin
          num_cases <= num_cases + CNT_W'(1);
          if (!verdict) total_errors <= total_errors + CNT_W'(1);
        end
        win_sr         <= (win_sr << 1) | WINDOW'(verdict);
        recent_correct <= rc_next;
        fill           <= fill_next;
        window_full    <= (fill_next == WIN_MAX);
      end
    end
  end

`ifdef SCORE_ACC_EN
  localparam int ACC_W = ACT_W + IDX_W;

  logic [ACT_W-1:0] y_fx;
  logic [ACT_W-1:0] abs_diff;
  logic [ACC_W-1:0] abs_acc;

  always_comb begin
    y_fx     = ACT_W'(y_out[0]) << FRAC;
    abs_diff = (act_in >= y_fx) ? (act_in - y_fx) : (y_fx - act_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abs_acc      <= '0;
      case_abs_err <= '0;
    end else if (commit) begin
      case_abs_err <= abs_acc + ACC_W'(abs_diff);
      abs_acc      <= '0;
    end else if (cycle_index == '0) begin
      abs_acc <= '0;
    end else if (scoring) begin
      abs_acc <= abs_acc + ACC_W'(abs_diff);
    end
  end
`endif

endmodule
